// File: rtl/pipelined_addsub_acc_if.sv
// Operand/result stream bundle for pipelined_addsub_acc: valid/ready on both sides.
interface pipelined_addsub_acc_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             flag;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, flag
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, flag
  );
endinterface

// File: rtl/pipelined_addsub_acc.sv
// Add/subtract/accumulate unit with a LATENCY-deep stallable pipeline.
// Stage 0 computes at accept; the last stage is the output register.
module pipelined_addsub_acc #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_addsub_acc_if.slave bus
);
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  op_e              op;
  logic             advance;
  logic             accept;
  logic [WIDTH:0]   acc;
  logic [WIDTH+1:0] acc_sum;
  logic [WIDTH:0]   res;
  logic             res_flag;

  logic [LATENCY-1:0] stage_valid;
  logic [LATENCY-1:0] stage_flag;
  logic [WIDTH:0]     stage_sum [LATENCY];

  assign op            = op_e'(bus.op);
  assign bus.out_valid = stage_valid[LATENCY-1];
  assign bus.sum       = stage_sum[LATENCY-1];
  assign bus.flag      = stage_flag[LATENCY-1];
  assign advance       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = advance;
  assign accept        = bus.in_valid && advance;
  assign acc_sum       = {1'b0, acc} + {2'b00, bus.a};

  always_comb begin
    res      = '0;
    res_flag = 1'b0;
    case (op)
      OP_ADD: begin
        res      = {1'b0, bus.a} + {1'b0, bus.b};
        res_flag = res[WIDTH];
      end
      OP_SUB: begin
        res      = {1'b0, bus.a} - {1'b0, bus.b};
        res_flag = (bus.a < bus.b);
      end
      OP_ACC: begin
        res      = acc_sum[WIDTH:0];
        res_flag = acc_sum[WIDTH+1];
      end
      default: begin
        res      = '0;
        res_flag = 1'b0;
      end
    endcase
  end

  // Data fields only move with a valid beat so sum/flag hold their last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      stage_flag  <= '0;
      acc         <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_sum[i] <= '0;
      end
    end else begin
      if (accept && op == OP_ACC) begin
        acc <= acc_sum[WIDTH:0];
      end else if (accept && op == OP_CLR) begin
        acc <= '0;
      end
      if (advance) begin
        stage_valid[0] <= accept;
        if (accept) begin
          stage_sum[0]  <= res;
          stage_flag[0] <= res_flag;
        end
        for (int unsigned i = 1; i < LATENCY; i++) begin
          stage_valid[i] <= stage_valid[i-1];
          if (stage_valid[i-1]) begin
            stage_sum[i]  <= stage_sum[i-1];
            stage_flag[i] <= stage_flag[i-1];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub_acc.sv
// Runs LATENCY=1/2/5 instances on one shared operand stream against an arithmetic scoreboard.
module tb_pipelined_addsub_acc;
  localparam int W = 4;

  typedef struct {
    logic [W:0] sum;
    logic       flag;
    int         cyc;
    logic       timed;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid_d = 1'b0;
  logic [W-1:0] a_d = '0;
  logic [W-1:0] b_d = '0;
  logic [1:0]   op_d = '0;
  logic         out_ready = 1'b1;
  logic [2:0]   pend = '0;
  int           or_mode = 0;
  logic         check_lat = 1'b0;
  int           cyc = 0;

  logic [W:0] cur_sum = '0;
  logic       cur_flag = 1'b0;
  int         macc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t       q [3][$];
  logic [2:0] hold_v = '0;
  logic [W:0] hold_s [3];
  logic       hold_f [3];

  pipelined_addsub_acc_if #(.WIDTH(W)) if1 ();
  pipelined_addsub_acc_if #(.WIDTH(W)) if2 ();
  pipelined_addsub_acc_if #(.WIDTH(W)) if5 ();

  assign if1.in_valid = in_valid_d & pend[0];
  assign if2.in_valid = in_valid_d & pend[1];
  assign if5.in_valid = in_valid_d & pend[2];
  assign if1.a = a_d;  assign if2.a = a_d;  assign if5.a = a_d;
  assign if1.b = b_d;  assign if2.b = b_d;  assign if5.b = b_d;
  assign if1.op = op_d; assign if2.op = op_d; assign if5.op = op_d;
  assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;
  assign if5.out_ready = out_ready;

  pipelined_addsub_acc #(.WIDTH(W), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  pipelined_addsub_acc #(.WIDTH(W), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  pipelined_addsub_acc #(.WIDTH(W), .LATENCY(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

  logic [2:0] ov, ir, iv, fl;
  logic [W:0] sm [3];
  assign ov = {if5.out_valid, if2.out_valid, if1.out_valid};
  assign ir = {if5.in_ready, if2.in_ready, if1.in_ready};
  assign iv = {if5.in_valid, if2.in_valid, if1.in_valid};
  assign fl = {if5.flag, if2.flag, if1.flag};
  assign sm[0] = if1.sum;
  assign sm[1] = if2.sum;
  assign sm[2] = if5.sum;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Plain-arithmetic reference for one beat; updates the model accumulator.
  task automatic model(input logic [1:0] op, input int a, input int b,
                       output logic [W:0] s, output logic f);
    int t;
    case (op)
      2'd0: begin t = a + b; s = t[W:0]; f = (t > 15); end
      2'd1: begin t = (a - b + 32) % 32; s = t[W:0]; f = (a < b); end
      2'd2: begin t = macc + a; f = (t > 31); macc = t % 32; s = macc[W:0]; end
      default: begin macc = 0; s = '0; f = 1'b0; end
    endcase
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int k = 0; k < 3; k++) q[k].delete();
      hold_v = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (hold_v[k]) begin
          check($sformatf("hold_valid_L%0d", lat_of(k)), {31'b0, ov[k]}, 32'd1);
          check($sformatf("hold_sum_L%0d", lat_of(k)), {27'b0, sm[k]}, {27'b0, hold_s[k]});
          check($sformatf("hold_flag_L%0d", lat_of(k)), {31'b0, fl[k]}, {31'b0, hold_f[k]});
        end
        if (ov[k] && !out_ready)
          check($sformatf("in_ready_stall_L%0d", lat_of(k)), {31'b0, ir[k]}, 32'd0);
        if (!ov[k])
          check($sformatf("in_ready_idle_L%0d", lat_of(k)), {31'b0, ir[k]}, 32'd1);
        if (ov[k] && out_ready) begin
          if (q[k].size() == 0) begin
            check($sformatf("spurious_out_L%0d", lat_of(k)), 32'd1, 32'd0);
          end else begin
            e = q[k].pop_front();
            check($sformatf("sum_L%0d", lat_of(k)), {27'b0, sm[k]}, {27'b0, e.sum});
            check($sformatf("flag_L%0d", lat_of(k)), {31'b0, fl[k]}, {31'b0, e.flag});
            if (e.timed && check_lat)
              check($sformatf("latency_L%0d", lat_of(k)), cyc - e.cyc, lat_of(k));
          end
        end
        if (iv[k] && ir[k]) q[k].push_back('{cur_sum, cur_flag, cyc, check_lat});
        hold_v[k] = ov[k] && !out_ready;
        hold_s[k] = sm[k];
        hold_f[k] = fl[k];
      end
    end
  end

  // Presents one beat until every instance has taken it exactly once.
  task automatic issue(input logic [1:0] op, input int a, input int b);
    logic [2:0] took;
    model(op, a, b, cur_sum, cur_flag);
    op_d = op;
    a_d = a[W-1:0];
    b_d = b[W-1:0];
    pend = 3'b111;
    in_valid_d = 1'b1;
    for (int t = 0; t < 200 && pend != 3'b000; t++) begin
      @(negedge clk);
      took = pend & ir;
      @(posedge clk); #1;
      pend = pend & ~took;
    end
    if (pend != 3'b000) check("accept_timeout", {29'b0, pend}, 32'd0);
    in_valid_d = 1'b0;
    pend = 3'b000;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", q[0].size() + q[1].size() + q[2].size(), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid_d = 1'b0;
    macc = 0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_L%0d", lat_of(k)), {31'b0, ov[k]}, 32'd0);
      check($sformatf("rst_sum_L%0d", lat_of(k)), {27'b0, sm[k]}, 32'd0);
      check($sformatf("rst_flag_L%0d", lat_of(k)), {31'b0, fl[k]}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset(3);

    check_lat = 1'b1;
    or_mode = 0;
    issue(2'd0, 9, 12);
    drain();
    issue(2'd0, 15, 15);
    issue(2'd1, 3, 5);
    issue(2'd1, 7, 7);
    drain();
    issue(2'd3, 0, 0);
    for (int i = 0; i < 3; i++) issue(2'd2, 15, 0);
    drain();

    check_lat = 1'b0;
    fork
      for (int i = 0; i < 6; i++) issue(2'd0, i + 3, 2 * i);
      begin
        repeat (3) begin @(posedge clk); #1; end
        or_mode = 1;
        repeat (4) begin @(posedge clk); #1; end
        or_mode = 0;
      end
    join
    drain();

    issue(2'd0, 1, 2);
    issue(2'd1, 9, 4);
    do_reset(1);
    repeat (8) begin @(posedge clk); #1; end
    check_lat = 1'b1;
    issue(2'd2, 1, 0);
    drain();

    check_lat = 1'b0;
    or_mode = 2;
    for (int i = 0; i < 80; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    or_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
